// File: rtl/bsg_manycore_block_mem_amo.sv
// bsg_manycore_block_mem_amo
// Pipelined block-memory endpoint for a manycore tile.
//   S0: request accept and array access (read, masked store).
//   S1: read data capture and atomic writeback.
//   Then an in-order response FIFO of resp_els_p entries. A credit counter
//   ensures every accepted request has a response slot.
// Optional feature macro: BSG_BLOCK_MEM_AMO_EN enables AMOSWAP/AMOADD/AMOOR.
// Without the macro, ops 2-4 are answered as illegal.
// Ports:
//   clk_i, reset_n_i        clock, async active-low reset
//   v_i/ready_o             request handshake; op_i, addr_i, data_i, mask_i, tag_i
//   v_o/yumi_i              response handshake; data_o, tag_o, err_o
module bsg_manycore_block_mem_amo #(
   parameter int data_width_p        = 32,
   parameter int mem_size_in_words_p = 1024,
   parameter int tag_width_p         = 8,
   parameter int resp_els_p          = 3,
   localparam int addr_width_lp = (mem_size_in_words_p > 1) ? $clog2(mem_size_in_words_p) : 1,
   localparam int mask_width_lp = data_width_p / 8
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     v_i,
   output logic                     ready_o,
   input  logic [2:0]               op_i,
   input  logic [addr_width_lp-1:0] addr_i,
   input  logic [data_width_p-1:0]  data_i,
   input  logic [mask_width_lp-1:0] mask_i,
   input  logic [tag_width_p-1:0]   tag_i,
   output logic                     v_o,
   output logic [data_width_p-1:0]  data_o,
   output logic [tag_width_p-1:0]   tag_o,
   output logic                     err_o,
   input  logic                     yumi_i
);

   localparam int cnt_width_lp = $clog2(resp_els_p + 1);
   localparam int ptr_width_lp = (resp_els_p > 1) ? $clog2(resp_els_p) : 1;

   localparam logic [2:0] op_load  = 3'd0;
   localparam logic [2:0] op_store = 3'd1;
   localparam logic [2:0] op_swap  = 3'd2;
   localparam logic [2:0] op_add   = 3'd3;
   localparam logic [2:0] op_or    = 3'd4;

   logic                     accept, pop, op_legal, addr_ok, req_err;
   logic                     rd_en, st_en;
   logic [cnt_width_lp-1:0]  credits_r;
   logic [31:0]              addr_ext;

   logic                     s1_v_r, s1_err_r, s1_ret_r;
   logic [tag_width_p-1:0]   s1_tag_r;
   logic [data_width_p-1:0]  rd_data_r, resp_data;

   logic [data_width_p-1:0]  mem_r [mem_size_in_words_p];

   // Widen before comparing so a power-of-two depth does not wrap the bound.
   assign addr_ext = 32'(addr_i);
   assign addr_ok  = addr_ext < 32'(mem_size_in_words_p);
   assign accept   = v_i & ready_o;
   assign req_err  = ~addr_ok | ~op_legal;
   assign rd_en    = accept & ~req_err & (op_i != op_store);
   assign st_en    = accept & ~req_err & (op_i == op_store);

`ifdef BSG_BLOCK_MEM_AMO_EN
   logic                     amo_wb_r, req_amo, wb_en;
   logic [2:0]               s1_op_r;
   logic [addr_width_lp-1:0] s1_addr_r;
   logic [data_width_p-1:0]  s1_operand_r, amo_new;

   assign req_amo  = (op_i == op_swap) | (op_i == op_add) | (op_i == op_or);
   assign op_legal = (op_i <= op_or);
   // The S1 writeback owns the array port, so no request is taken that cycle.
   assign ready_o  = (credits_r != '0) & ~amo_wb_r;
   assign wb_en    = s1_v_r & s1_ret_r & (s1_op_r != op_load);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         amo_wb_r     <= 1'b0;
         s1_op_r      <= op_load;
         s1_addr_r    <= '0;
         s1_operand_r <= '0;
      end else begin
         amo_wb_r <= accept & req_amo;
         if (accept) begin
            s1_op_r      <= op_i;
            s1_addr_r    <= addr_i;
            s1_operand_r <= data_i;
         end
      end
   end

   always_comb begin
      amo_new = s1_operand_r;
      case (s1_op_r)
         op_add:  amo_new = rd_data_r + s1_operand_r;
         op_or:   amo_new = rd_data_r | s1_operand_r;
         default: amo_new = s1_operand_r;
      endcase
   end
`else
   assign op_legal = (op_i <= op_store);
   assign ready_o  = (credits_r != '0);
`endif

   // Storage array: not reset. A store lands at the end of its S0 cycle, so a
   // load accepted in the next cycle reads the new value.
   always_ff @(posedge clk_i) begin
      if (rd_en) rd_data_r <= mem_r[addr_i];
`ifdef BSG_BLOCK_MEM_AMO_EN
      if (wb_en) mem_r[s1_addr_r] <= amo_new;
`endif
      if (st_en) begin
         for (int b = 0; b < mask_width_lp; b++) begin
            if (mask_i[b]) mem_r[addr_i][8*b +: 8] <= data_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         s1_v_r   <= 1'b0;
         s1_err_r <= 1'b0;
         s1_ret_r <= 1'b0;
         s1_tag_r <= '0;
      end else begin
         s1_v_r   <= accept;
         s1_err_r <= accept & req_err;
         s1_ret_r <= rd_en;
         if (accept) s1_tag_r <= tag_i;
      end
   end

   assign resp_data = s1_ret_r ? rd_data_r : '0;

   // Response FIFO; credits guarantee it never overflows.
   logic [data_width_p-1:0] q_data [resp_els_p];
   logic [tag_width_p-1:0]  q_tag  [resp_els_p];
   logic                    q_err  [resp_els_p];
   logic [ptr_width_lp-1:0] wr_ptr_r, rd_ptr_r;
   logic [cnt_width_lp-1:0] count_r;

   assign pop = yumi_i & v_o;

   always_ff @(posedge clk_i) begin
      if (s1_v_r) begin
         q_data[wr_ptr_r] <= resp_data;
         q_tag[wr_ptr_r]  <= s1_tag_r;
         q_err[wr_ptr_r]  <= s1_err_r;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_r  <= '0;
         rd_ptr_r  <= '0;
         count_r   <= '0;
         credits_r <= cnt_width_lp'(resp_els_p);
      end else begin
         if (s1_v_r)
            wr_ptr_r <= (wr_ptr_r == ptr_width_lp'(resp_els_p - 1)) ? '0 : wr_ptr_r + 1'b1;
         if (pop)
            rd_ptr_r <= (rd_ptr_r == ptr_width_lp'(resp_els_p - 1)) ? '0 : rd_ptr_r + 1'b1;
         case ({s1_v_r, pop})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
         case ({accept, pop})
            2'b10:   credits_r <= credits_r - 1'b1;
            2'b01:   credits_r <= credits_r + 1'b1;
            default: credits_r <= credits_r;
         endcase
      end
   end

   // Outputs are forced to zero while empty so idle and reset values are clean.
   assign v_o    = (count_r != '0);
   assign data_o = v_o ? q_data[rd_ptr_r] : '0;
   assign tag_o  = v_o ? q_tag[rd_ptr_r]  : '0;
   assign err_o  = v_o ? q_err[rd_ptr_r]  : 1'b0;

endmodule
